// File: rtl/riscv_v_uop_sequencer_pkg.sv
// Shared types for the vector uop sequencer: SEW encoding, FSM states, elements-per-uop helper.
// Pure declarations; no latency or backpressure of its own.
package riscv_v_pkg;

    typedef enum logic [1:0] {
        E8  = 2'd0,
        E16 = 2'd1,
        E32 = 2'd2,
        E64 = 2'd3
    } sew_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Elements of width SEW that fit in one lane word.
    function automatic int epu_f(input sew_e sew, input int data_w);
        return data_w >> (3 + int'(sew));
    endfunction

endpackage

// File: rtl/riscv_v_uop_sequencer_if.sv
// Instruction-in / uop-out bundle of the sequencer; slave = sequencer, master = issuer and lane.
// Both directions use valid/ready; the master must hold payload while valid && !ready.
interface riscv_v_uop_sequencer_if
    import riscv_v_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    localparam int VL_W   = $clog2(VLEN) + 1;
    localparam int UIDX_W = $clog2(VLEN * 8 / DATA_W);
    localparam int BE_W   = DATA_W / 8;

    logic              in_valid;
    logic              in_ready;
    logic [VL_W-1:0]   in_vl;
    sew_e              in_sew;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [UIDX_W-1:0] out_idx;
    logic              out_first;
    logic              out_last;
    logic [BE_W-1:0]   out_be;
    sew_e              out_sew;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_vl, in_sew, in_tag, out_ready,
        output in_ready, out_valid, out_idx, out_first, out_last, out_be, out_sew, out_tag
    );

    modport master (
        output in_valid, in_vl, in_sew, in_tag, out_ready,
        input  in_ready, out_valid, out_idx, out_first, out_last, out_be, out_sew, out_tag
    );

endinterface

// File: rtl/riscv_v_uop_sequencer_tail_mask_gen.sv
// Tail byte-enable mask for a uop: all ones unless last, then the low (rem << sew) bytes.
// Purely combinational, zero latency; no handshake.
module riscv_v_tail_mask_gen
    import riscv_v_pkg::*;
#(
    parameter int VL_W = 8,
    parameter int BE_W = 8
) (
    input  logic [VL_W-1:0] rem,
    input  sew_e            sew,
    input  logic            last,
    output logic [BE_W-1:0] be
);

    logic [VL_W+2:0] nbytes;

    always_comb begin
        nbytes = {3'b000, rem} << sew;
        be     = '0;
        for (int i = 0; i < BE_W; i++) begin
            be[i] = !last || ((VL_W + 3)'(i) < nbytes);
        end
    end

endmodule

// File: rtl/riscv_v_uop_sequencer.sv
// Splits one vector instruction (vl, SEW) into DATA_W-wide uops; uop 0 appears the cycle after accept.
// Uop outputs hold while out_ready is low; a new instruction is taken only when idle or on the last uop's fire.
module riscv_v_uop_sequencer
    import riscv_v_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    riscv_v_uop_sequencer_if.slave  io
);

    localparam int VL_W   = $clog2(VLEN) + 1;
    localparam int UIDX_W = $clog2(VLEN * 8 / DATA_W);
    localparam int BE_W   = DATA_W / 8;

    seq_state_e        state_q, state_d;
    logic [VL_W-1:0]   rem_q,   rem_d;
    logic [UIDX_W-1:0] idx_q,   idx_d;
    sew_e              sew_q,   sew_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;

    logic              out_valid;
    logic              out_last;
    logic              fire;
    logic              in_ready;
    logic              accept;
    logic [VL_W-1:0]   epu;
    logic [BE_W-1:0]   tail_be;

    assign epu       = VL_W'(epu_f(sew_q, DATA_W));
    assign out_valid = (state_q == RUN);
    assign out_last  = out_valid && (rem_q <= epu);
    assign fire      = out_valid && io.out_ready;
    assign in_ready  = !flush && ((state_q == IDLE) || (fire && out_last));
    assign accept    = io.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        sew_d   = sew_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
            idx_d   = '0;
        end else begin
            if (fire) begin
                rem_d = rem_q - epu;
                idx_d = idx_q + 1'b1;
                if (out_last) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    idx_d   = '0;
                end
            end
            // A zero-length instruction is consumed here without producing any uop.
            if (accept) begin
                rem_d = '0;
                idx_d = '0;
                if (io.in_vl != '0) begin
                    state_d = RUN;
                    rem_d   = io.in_vl;
                    sew_d   = io.in_sew;
                    tag_d   = io.in_tag;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            sew_q   <= E8;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            sew_q   <= sew_d;
            tag_q   <= tag_d;
        end
    end

    riscv_v_tail_mask_gen #(
        .VL_W (VL_W),
        .BE_W (BE_W)
    ) u_tail_mask (
        .rem  (rem_q),
        .sew  (sew_q),
        .last (out_last),
        .be   (tail_be)
    );

    // Downstream stage enable is out_valid && out_ready; its flush is tied to the same flush.
    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.out_idx   = idx_q;
    assign io.out_first = out_valid && (idx_q == '0);
    assign io.out_last  = out_last;
    assign io.out_be    = out_valid ? tail_be : '0;
    assign io.out_sew   = sew_q;
    assign io.out_tag   = tag_q;

endmodule
